// File: rtl/clk_div_ctrl_pkg.sv
// Shared constants for the clock-divider controller: state encoding,
// minimum legal ratio and default counter width.
package clk_div_ctrl_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int DIV_MIN   = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/clk_div_ctrl_cnt.sv
// Period counter for the clock divider: counts 0..cur_div-1 while running,
// flags the last cycle of a period and decodes the divided-clock level and tick.
module clk_div_ctrl_cnt
    import clk_div_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_cur_div,
    output logic             o_bnd,
    output logic             o_div_clk,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_half;

    // One extra bit so the round-up of the largest ratio does not wrap to zero.
    assign w_half    = ({1'b0, i_cur_div} + {{CNT_W{1'b0}}, 1'b1}) >> 1;

    assign o_bnd     = i_run && (r_cnt == i_cur_div - CNT_W'(1));
    assign o_tick    = i_run && (r_cnt == '0);
    assign o_div_clk = i_run && ({1'b0, r_cnt} < w_half);

    always_ff @(posedge clk) begin
        if (!rst_n || !i_run || o_bnd) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: enable/drain sequencing and ratio handshake that
// swaps the ratio only at period boundaries. Optional tick counter output is
// enabled by defining CLK_DIV_CTRL_TICK_CNT_EN.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_valid,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ready,
    output logic             div_clk_o,
    output logic             tick_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] cur_div_o,
    output logic             err_o
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    ,
    output logic [15:0]      tick_cnt_o
`endif
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cur_div;
    logic [CNT_W-1:0] r_nxt_div;
    logic             r_pend;
    logic             r_err;

    logic             w_run;
    logic             w_bnd;
    logic             w_xfer;
    logic             w_legal;

    assign w_run   = (r_state != ST_IDLE);
    assign w_xfer  = div_valid && !r_pend;
    assign w_legal = (div_val >= CNT_W'(DIV_MIN));

    clk_div_ctrl_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_run     (w_run),
        .i_cur_div (r_cur_div),
        .o_bnd     (w_bnd),
        .o_div_clk (div_clk_o),
        .o_tick    (tick_o)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (en) w_state_nxt = ST_RUN;
            ST_RUN:   if (!en) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (en)         w_state_nxt = ST_RUN;
                else if (w_bnd) w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cur_div <= CNT_W'(DEFAULT_DIV);
            r_nxt_div <= '0;
            r_pend    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_xfer && !w_legal;
            // A pending ratio blocks new transfers, so these branches never collide.
            if (w_bnd && r_pend) begin
                r_cur_div <= r_nxt_div;
                r_pend    <= 1'b0;
            end else if (w_xfer && w_legal) begin
                if (!w_run || w_bnd) begin
                    r_cur_div <= div_val;
                end else begin
                    r_nxt_div <= div_val;
                    r_pend    <= 1'b1;
                end
            end
        end
    end

    assign div_ready = !r_pend;
    assign busy_o    = w_run;
    assign cur_div_o = r_cur_div;
    assign err_o     = r_err;

`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    logic [15:0] r_tick_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (tick_o) begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
        end
    end

    assign tick_cnt_o = r_tick_cnt;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed vector table, tick counter
// sequence and a randomized run against a period-level reference model.
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       div_valid = 1'b0;
    logic [7:0] div_val = 8'd0;
    logic       div_ready, div_clk_o, tick_o, busy_o, err_o;
    logic [7:0] cur_div_o;
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    logic [15:0] tick_cnt_o;
`endif

    clk_div_ctrl #(.CNT_W(8), .DEFAULT_DIV(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .div_valid (div_valid),
        .div_val   (div_val),
        .div_ready (div_ready),
        .div_clk_o (div_clk_o),
        .tick_o    (tick_o),
        .busy_o    (busy_o),
        .cur_div_o (cur_div_o),
        .err_o     (err_o)
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
        ,
        .tick_cnt_o(tick_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d at t=%0t", nm, act, exp, $time);
    endtask

    // Reference model: running flag, stop request, position within the period,
    // ratio in force and at most one queued ratio.
    bit m_act, m_stop, m_pend, m_err;
    int m_phase, m_ratio, m_pval, m_tcnt;

    task automatic model_edge();
        bit last, xfer, legal, tick_now;
        if (!rst_n) begin
            m_act = 0; m_stop = 0; m_pend = 0; m_err = 0;
            m_phase = 0; m_ratio = 3; m_pval = 0; m_tcnt = 0;
        end else begin
            tick_now = m_act && (m_phase == 0);
            last  = m_act && (m_phase == m_ratio - 1);
            xfer  = div_valid && !m_pend;
            legal = (div_val >= 2);
            m_err = xfer && !legal;
            m_tcnt = (m_tcnt + int'(tick_now)) % 65536;
            if (m_act) m_phase = last ? 0 : m_phase + 1;
            else       m_phase = 0;
            if (last && m_pend) begin
                m_ratio = m_pval; m_pend = 0;
            end else if (xfer && legal) begin
                if (!m_act || last) m_ratio = int'(div_val);
                else begin m_pval = int'(div_val); m_pend = 1; end
            end
            if (!m_act) begin
                if (en) begin m_act = 1; m_stop = 0; end
            end else if (!m_stop) begin
                if (!en) m_stop = 1;
            end else begin
                if (en) m_stop = 0;
                else if (last) begin m_act = 0; m_stop = 0; end
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        chk("rnd_tick",  int'(tick_o),    int'(m_act && m_phase == 0));
        chk("rnd_clk",   int'(div_clk_o), int'(m_act && (2 * m_phase < m_ratio)));
        chk("rnd_ready", int'(div_ready), int'(!m_pend));
        chk("rnd_busy",  int'(busy_o),    int'(m_act));
        chk("rnd_cur",   int'(cur_div_o), m_ratio);
        chk("rnd_err",   int'(err_o),     int'(m_err));
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
        chk("rnd_tcnt",  int'(tick_cnt_o), m_tcnt);
`endif
    endtask

    typedef struct {
        bit rst, en, dv;
        int dval;
        bit tk, ck, rd, bz;
        int cur;
        bit er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit rst, bit e, bit dv, int dval,
                               bit tk, bit ck, bit rd, bit bz, int cur, bit er);
        vec_t r;
        r.rst = rst; r.en = e; r.dv = dv; r.dval = dval;
        r.tk = tk; r.ck = ck; r.rd = rd; r.bz = bz; r.cur = cur; r.er = er;
        return r;
    endfunction

    initial begin
        // Inputs sampled at an edge; expected outputs are those seen just after it.
        tbl.push_back(v(0,0,0,0, 0,0,1,0,3,0));  // reset state
        tbl.push_back(v(1,1,0,0, 1,1,1,1,3,0));  // first tick one cycle after en
        tbl.push_back(v(1,1,0,0, 0,1,1,1,3,0));
        tbl.push_back(v(1,1,0,0, 0,0,1,1,3,0));
        tbl.push_back(v(1,1,0,0, 1,1,1,1,3,0));
        tbl.push_back(v(1,1,1,5, 0,1,0,1,3,0));  // mid-period offer -> pending
        tbl.push_back(v(1,1,0,0, 0,0,0,1,3,0));
        tbl.push_back(v(1,1,0,0, 1,1,1,1,5,0));  // ratio 5 from this tick
        tbl.push_back(v(1,1,0,0, 0,1,1,1,5,0));
        tbl.push_back(v(1,1,0,0, 0,1,1,1,5,0));
        tbl.push_back(v(1,1,0,0, 0,0,1,1,5,0));
        tbl.push_back(v(1,1,0,0, 0,0,1,1,5,0));
        tbl.push_back(v(1,1,1,4, 1,1,1,1,4,0));  // offer on boundary
        tbl.push_back(v(1,1,0,0, 0,1,1,1,4,0));
        tbl.push_back(v(1,1,0,0, 0,0,1,1,4,0));
        tbl.push_back(v(1,1,0,0, 0,0,1,1,4,0));
        tbl.push_back(v(1,1,0,0, 1,1,1,1,4,0));
        tbl.push_back(v(1,1,1,1, 0,1,1,1,4,1));  // illegal 1
        tbl.push_back(v(1,1,1,0, 0,0,1,1,4,1));  // illegal 0
        tbl.push_back(v(1,1,0,0, 0,0,1,1,4,0));
        tbl.push_back(v(1,1,0,0, 1,1,1,1,4,0));
        tbl.push_back(v(1,1,0,0, 0,1,1,1,4,0));
        tbl.push_back(v(1,0,0,0, 0,0,1,1,4,0));  // en dropped at cnt=1
        tbl.push_back(v(1,0,0,0, 0,0,1,1,4,0));
        tbl.push_back(v(1,0,0,0, 0,0,1,0,4,0));  // idle after boundary
        tbl.push_back(v(1,0,0,0, 0,0,1,0,4,0));
        tbl.push_back(v(1,1,0,0, 1,1,1,1,4,0));
        tbl.push_back(v(1,0,0,0, 0,1,1,1,4,0));  // drain
        tbl.push_back(v(1,1,0,0, 0,0,1,1,4,0));  // re-raised
        tbl.push_back(v(1,1,0,0, 0,0,1,1,4,0));
        tbl.push_back(v(1,1,0,0, 1,1,1,1,4,0));  // no gap
        tbl.push_back(v(1,1,1,7, 0,1,0,1,4,0));  // pending 7
        tbl.push_back(v(0,1,0,0, 0,0,1,0,3,0));  // reset drops it
        tbl.push_back(v(1,1,0,0, 1,1,1,1,3,0));
        tbl.push_back(v(1,1,0,0, 0,1,1,1,3,0));
        tbl.push_back(v(1,1,0,0, 0,0,1,1,3,0));
        tbl.push_back(v(1,1,0,0, 1,1,1,1,3,0));

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst; en = tbl[i].en;
            div_valid = tbl[i].dv; div_val = 8'(tbl[i].dval);
            step();
            chk($sformatf("v%0d_tick", i),  int'(tick_o),    int'(tbl[i].tk));
            chk($sformatf("v%0d_clk", i),   int'(div_clk_o), int'(tbl[i].ck));
            chk($sformatf("v%0d_ready", i), int'(div_ready), int'(tbl[i].rd));
            chk($sformatf("v%0d_busy", i),  int'(busy_o),    int'(tbl[i].bz));
            chk($sformatf("v%0d_cur", i),   int'(cur_div_o), tbl[i].cur);
            chk($sformatf("v%0d_err", i),   int'(err_o),     int'(tbl[i].er));
        end

`ifdef CLK_DIV_CTRL_TICK_CNT_EN
        begin
            int seen = 0;
            rst_n = 0; en = 0; div_valid = 0;
            step();
            chk("tcnt_reset", int'(tick_cnt_o), 0);
            rst_n = 1; en = 1;
            for (int c = 0; c < 100 && seen < 10; c++) begin
                step();
                if (tick_o) seen++;
            end
            chk("tcnt_seen10", seen, 10);
            step();
            chk("tcnt_10", int'(tick_cnt_o), 10);
        end
`endif

        // Randomized run against the model.
        rst_n = 0; en = 0; div_valid = 0;
        step();
        check_model();
        for (int c = 0; c < 3000; c++) begin
            int r;
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 14) == 0) en = ~en;
            div_valid = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 39);
            if (r < 3)        div_val = 8'(r);
            else if (r == 39) div_val = 8'd255;
            else if (r == 38) div_val = 8'd254;
            else              div_val = 8'($urandom_range(2, 9));
            step();
            check_model();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Controller for the integer clock-divider datapath.
- Sequences enable and disable of a single-clock programmable divider, and accepts new divide ratios over a valid/ready handshake.
- Applies ratio changes only at period boundaries, so no runt or stretched periods appear.
- Drives a divided-clock level and a one-cycle period tick to downstream logic. Sits between the config/CSR side and the divider consumers.

Parameters:
- CNT_W, 8, width of divide ratio and period counter.
- DEFAULT_DIV, 3, ratio loaded at reset; must be >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  run request; level-sensitive
- div_valid  in  1  new ratio offered
- div_val  in  CNT_W  offered ratio
- div_ready  out  1  controller can accept a ratio
- div_clk_o  out  1  divided clock level
- tick_o  out  1  one-cycle pulse on the first cycle of each output period
- busy_o  out  1  state != IDLE
- cur_div_o  out  CNT_W  ratio currently in effect
- err_o  out  1  one-cycle pulse when an illegal ratio (0 or 1) is accepted

Behaviour:
- Reset (rst_n=0 sampled at posedge clk):
  - state=IDLE, cnt=0, cur_div=DEFAULT_DIV, pend=0.
  - Outputs: div_clk_o=0, tick_o=0, err_o=0, busy_o=0, div_ready=1, cur_div_o=DEFAULT_DIV.
  - Reset mid-period aborts immediately; any pending ratio is discarded.
- States: IDLE, RUN, DRAIN. Separate pend flag plus nxt_div register.
- IDLE:
  - cnt=0, div_clk_o=0.
  - en=1 -> RUN next cycle with cnt=0. First tick_o is therefore 1 cycle after en is sampled high.
- RUN:
  - cnt counts 0..cur_div-1 and wraps.
  - tick_o=1 when cnt==0.
  - div_clk_o=1 when cnt < (cur_div+1)>>1. For ratio 3: high 2 cycles, low 1. For ratio 4: 2/2.
  - Boundary = cycle with cnt==cur_div-1.
  - en=0 sampled -> DRAIN.
- DRAIN:
  - Continues counting identically to RUN.
  - At the boundary -> IDLE, and div_clk_o is low from the next cycle.
  - en=1 during DRAIN -> RUN next cycle; no period disturbance.
- Handshake: div_ready = !pend. A transfer occurs when div_valid && div_ready.
  - In IDLE: cur_div updates the next cycle; pend is not set.
  - In RUN/DRAIN, transfer not on a boundary: nxt_div captured, pend=1. At the next boundary, cur_div<=nxt_div, pend<=0 and cnt<=0.
  - In RUN/DRAIN, transfer on a boundary cycle: the new ratio applies at that same boundary; pend is never set.
  - Illegal value (div_val<2): transfer completes, err_o pulses the next cycle, and cur_div and pend are unchanged.
  - div_valid while div_ready=0: ignored; the requester must hold div_valid.
- cur_div_o changes in the same cycle cnt restarts at 0 with the new ratio.
- Arithmetic:
  - Unsigned CNT_W-bit throughout.
  - The (cur_div+1)>>1 compare uses a CNT_W+1-bit intermediate, so that ratio 2^CNT_W-1 is correct.

Optional Feature:
- Macro: CLK_DIV_CTRL_TICK_CNT_EN.
- Defined: adds output tick_cnt_o[15:0], which increments on every tick_o, wraps 0xFFFF->0, and clears on reset.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Decomposition:
- Package clk_div_ctrl_pkg holds:
  - state enum {IDLE, RUN, DRAIN};
  - localparam DIV_MIN=2;
  - default CNT_W.
- One natural sub-module, clk_div_ctrl_cnt: period counter, boundary flag and div_clk_o/tick_o decode, with inputs run, cur_div.
- The FSM and handshake stay in the top module.

Test Plan:
- Reset release, en=1 at cycle 0, DEFAULT_DIV=3 -> tick_o at cycles 1,4,7,...; div_clk_o pattern 1,1,0 repeating; busy_o=1.
- RUN at ratio 3, offer div_val=5 mid-period -> div_ready drops for one or more cycles. The current 3-cycle period completes, then periods are 5 cycles with div_clk_o 1,1,1,0,0, and cur_div_o=5 on the first new tick.
- Offer div_val=4 exactly on a boundary cycle -> next period is 4 cycles and div_ready never drops.
- Offer div_val=1, then div_val=0 -> err_o pulses once per transfer; the ratio and period stay unchanged.
- Ratio 4: drop en at cnt=1 -> the period completes (cnt reaches 3) and then IDLE with div_clk_o=0. Separately, drop en and re-raise it before the boundary -> no gap in ticks.
- With a pending ratio (pend=1), assert rst_n=0 for 1 cycle -> IDLE, cur_div_o=3, div_ready=1, and the pending value is lost. With CLK_DIV_CTRL_TICK_CNT_EN defined, tick_cnt_o=0 after reset and equals 10 after 10 ticks.
